// File: rtl/alu_seq_muldiv_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU and its
// multiply/divide engine.
package alu_seq_muldiv_pkg;

  localparam int ALU_OPW = 4;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLT   = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_MUL   = 4'd11,
    ALU_MULHU = 4'd12,
    ALU_DIVU  = 4'd13,
    ALU_REMU  = 4'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_iter_op(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU};
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return op inside {ALU_DIVU, ALU_REMU};
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// One-bit-per-cycle engine: shift-add multiply over a 2*WIDTH accumulator or
// restoring unsigned divide; done flags the cycle whose update is the last one.
module alu_seq_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  // Multiply: {hi, lo} = {partial sum, remaining multiplier bits}.
  // Divide:   {hi, lo} = {partial remainder, dividend shifting into quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   b_q;
  logic               div_q;
  logic [CNTW-1:0]    cnt;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_next  = acc;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_q : '0)};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_diff  = div_shift[WIDTH-1:0] - b_q;
    if (div_q) begin
      acc_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                        : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // The final iteration's value is presented combinationally so the caller
  // can register it on the same edge the counter passes 1.
  assign done = (cnt == CNTW'(1));
  assign lo   = acc_next[WIDTH-1:0];
  assign hi   = acc_next[2*WIDTH-1:WIDTH];

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race readers.
  // NOTE: datapath registers are reset too, so no stale operand is ever observable after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      acc   <= {{WIDTH{1'b0}}, a};
      b_q   <= b;
      div_q <= div_mode;
      cnt   <= CNTW'(WIDTH);
    end else if (cnt != '0) begin
      acc   <= acc_next;
      cnt   <= cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with valid/ready handshake: single-cycle ops finish in one
// cycle, multiply/divide run WIDTH cycles in the iterative engine.
module alu_seq_muldiv
  import alu_seq_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state;
  alu_op_e          op_q;
  alu_op_e          op_in;
  logic             op_hi_nz;
  logic             accept;
  logic             go_iter;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf;
  logic             sc_err;

  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_res;

  // Opcode bits above the defined encoding space make the op illegal.
  if (OPW > ALU_OPW) begin : g_wide_op
    assign op_hi_nz = |opcode[OPW-1:ALU_OPW];
  end else begin : g_narrow_op
    assign op_hi_nz = 1'b0;
  end

  assign op_in  = alu_op_e'(opcode[ALU_OPW-1:0]);
  assign shamt  = regb[SHW-1:0];
  assign accept = in_valid && in_ready;
  // Divide by zero is resolved in one cycle by the single-cycle path.
  assign go_iter = !op_hi_nz && is_iter_op(op_in) && !(is_div_op(op_in) && (regb == '0));

  always_comb begin
    add_res   = rega + regb;
    sub_res   = rega - regb;
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_err    = 1'b0;
    case (op_in)
      ALU_ADD: begin
        sc_result = add_res;
        sc_ovf    = (rega[WIDTH-1] == regb[WIDTH-1]) && (add_res[WIDTH-1] != rega[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_result = sub_res;
        sc_ovf    = (rega[WIDTH-1] != regb[WIDTH-1]) && (sub_res[WIDTH-1] != rega[WIDTH-1]);
      end
      ALU_AND:   sc_result = rega & regb;
      ALU_OR:    sc_result = rega | regb;
      ALU_XOR:   sc_result = rega ^ regb;
      ALU_NOR:   sc_result = ~(rega | regb);
      ALU_SLTU:  sc_result = {{(WIDTH-1){1'b0}}, (rega < regb)};
      ALU_SLT:   sc_result = {{(WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
      ALU_SLL:   sc_result = rega << shamt;
      ALU_SRL:   sc_result = rega >> shamt;
      ALU_SRA:   sc_result = $unsigned($signed(rega) >>> shamt);
      ALU_MUL, ALU_MULHU: sc_result = '0;
      ALU_DIVU: begin
        sc_result = '1;
        sc_err    = 1'b1;
      end
      ALU_REMU: begin
        sc_result = rega;
        sc_err    = 1'b1;
      end
      default:   sc_err = 1'b1;
    endcase
    if (op_hi_nz) begin
      sc_result = '0;
      sc_ovf    = 1'b0;
      sc_err    = 1'b1;
    end
  end

  alu_seq_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && go_iter),
    .div_mode (is_div_op(op_in)),
    .a        (rega),
    .b        (regb),
    .done     (iter_done),
    .lo       (iter_lo),
    .hi       (iter_hi)
  );

  assign iter_res = ((op_q == ALU_MUL) || (op_q == ALU_DIVU)) ? iter_lo : iter_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= ALU_ADD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            op_q     <= op_in;
            if (go_iter) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= sc_result;
              zero      <= (sc_result == '0);
              ovf       <= sc_ovf;
              err       <= sc_err;
            end
          end
        end
        ST_BUSY: begin
          if (iter_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= iter_res;
            zero      <= (iter_res == '0);
            ovf       <= 1'b0;
            err       <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at WIDTH=32 and WIDTH=8; expected results
// are queued when an op is offered and compared when out_valid appears.
module tb_alu_seq_muldiv;
  import alu_seq_muldiv_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;

  logic        iv32, ir32, ov32, ordy32, z32, ovf32, err32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, res32;

  logic        iv8, ir8, ov8, ordy8, z8, ovf8, err8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, res8;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;

  alu_seq_muldiv #(.WIDTH(32)) dut32 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv32), .in_ready (ir32), .opcode (op32), .rega (a32), .regb (b32),
    .out_valid (ov32), .out_ready (ordy32), .result (res32),
    .zero (z32), .ovf (ovf32), .err (err32)
  );

  alu_seq_muldiv #(.WIDTH(8)) dut8 (
    .clk (clk), .rst_n (rst_n),
    .in_valid (iv8), .in_ready (ir8), .opcode (op8), .rega (a8), .regb (b8),
    .out_valid (ov8), .out_ready (ordy8), .result (res8),
    .zero (z8), .ovf (ovf8), .err (err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input int sel);
    return (sel == 0) ? ov32 : ov8;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel == 0) ? ir32 : ir8;
  endfunction
  function automatic logic [31:0] get_res(input int sel);
    return (sel == 0) ? res32 : {24'd0, res8};
  endfunction
  function automatic logic get_z(input int sel);
    return (sel == 0) ? z32 : z8;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? ovf32 : ovf8;
  endfunction
  function automatic logic get_err(input int sel);
    return (sel == 0) ? err32 : err8;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      iv32 = v; op32 = op; a32 = a; b32 = b;
    end else begin
      iv8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic set_ordy(input int sel, input logic v);
    if (sel == 0) ordy32 = v;
    else          ordy8  = v;
  endtask

  // Offer one op, wait for out_valid, compare against the queued expectation,
  // optionally stall the consumer for hold cycles, then complete the handshake.
  task automatic run_op(input int sel, input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic ez, input logic eovf,
                        input logic eerr, input int elat, input int hold);
    exp_t e;
    int   lat;
    e.tag = tag; e.res = eres; e.zero = ez; e.ovf = eovf; e.err = eerr; e.lat = elat;
    sb.push_back(e);
    check({tag, ":in_ready"}, 64'(get_ir(sel)), 64'd1);
    drive(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(sel, 1'b0, op, a, b);
    lat = 1;
    while (!get_ov(sel) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({e.tag, ":latency"}, 64'(lat), 64'(e.lat));
    check({e.tag, ":result"}, 64'(get_res(sel)), 64'(e.res));
    check({e.tag, ":zero"}, 64'(get_z(sel)), 64'(e.zero));
    check({e.tag, ":ovf"}, 64'(get_ovf(sel)), 64'(e.ovf));
    check({e.tag, ":err"}, 64'(get_err(sel)), 64'(e.err));
    for (int i = 0; i < hold; i++) begin
      drive(sel, 1'b1, ALU_ADD, 32'h1, 32'h1);
      @(posedge clk); #1;
      check({e.tag, ":hold_result"}, 64'(get_res(sel)), 64'(e.res));
      check({e.tag, ":hold_in_ready"}, 64'(get_ir(sel)), 64'd0);
      check({e.tag, ":hold_out_valid"}, 64'(get_ov(sel)), 64'd1);
    end
    drive(sel, 1'b0, ALU_ADD, 32'h0, 32'h0);
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    check({e.tag, ":release_out_valid"}, 64'(get_ov(sel)), 64'd0);
    check({e.tag, ":release_in_ready"}, 64'(get_ir(sel)), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] prod;
    int          seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 4'd0, 32'd0, 32'd0);
    ordy32 = 1'b0;
    ordy8  = 1'b0;

    #12;
    check("reset:in_ready", 64'(ir32), 64'd1);
    check("reset:out_valid", 64'(ov32), 64'd0);
    check("reset:result", 64'(res32), 64'd0);
    check("reset:zero", 64'(z32), 64'd1);
    check("reset:ovf", 64'(ovf32), 64'd0);
    check("reset:err", 64'(err32), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, "add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1, 0);
    run_op(0, "sub_zero", ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
    run_op(0, "sub_ovf", ALU_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1, 0);
    run_op(0, "and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "or", ALU_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "nor", ALU_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "slt", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1, 0);
    run_op(0, "sll", ALU_SLL, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "srl", ALU_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "sra", ALU_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(0, "mul", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op(0, "mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op(0, "divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op(0, "remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 33, 0);
    run_op(0, "divu_by0", ALU_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op(0, "remu_by0", ALU_REMU, 32'h1234, 32'h0, 32'h1234, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op(0, "illegal", 4'd15, 32'h55, 32'h66, 32'h0, 1'b1, 1'b0, 1'b1, 1, 0);

    for (int i = 0; i < 2; i++) begin
      ra = $urandom;
      rb = $urandom;
      prod = 64'(ra) * 64'(rb);
      run_op(0, "rnd_mul", ALU_MUL, ra, rb, prod[31:0], (prod[31:0] == 32'd0), 1'b0, 1'b0, 33, 0);
      run_op(0, "rnd_mulhu", ALU_MULHU, ra, rb, prod[63:32], (prod[63:32] == 32'd0), 1'b0, 1'b0, 33, 0);
      rb = $urandom_range(1, 32'hFFFF);
      run_op(0, "rnd_divu", ALU_DIVU, ra, rb, ra / rb, ((ra / rb) == 32'd0), 1'b0, 1'b0, 33, 0);
      run_op(0, "rnd_remu", ALU_REMU, ra, rb, ra % rb, ((ra % rb) == 32'd0), 1'b0, 1'b0, 33, 0);
    end

    run_op(0, "hold32", ALU_XOR, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b0, 1, 10);

    // Leave a nonzero result, then abandon a divide five cycles into BUSY.
    run_op(0, "pre_rst", ALU_DIVU, 32'h77, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1, 0);
    drive(0, 1'b1, ALU_DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(0, 1'b0, ALU_ADD, 32'd0, 32'd0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst:out_valid", 64'(ov32), 64'd0);
    check("midrst:in_ready", 64'(ir32), 64'd1);
    check("midrst:result", 64'(res32), 64'd0);
    check("midrst:zero", 64'(z32), 64'd1);
    check("midrst:err", 64'(err32), 64'd0);
    #2;
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) seen = 1;
    end
    check("midrst:no_partial_result", 64'(seen), 64'd0);
    run_op(0, "post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1, 0);

    run_op(1, "w8_add_ovf", ALU_ADD, 32'h7F, 32'h1, 32'h80, 1'b0, 1'b1, 1'b0, 1, 0);
    run_op(1, "w8_sra", ALU_SRA, 32'h80, 32'h4, 32'hF8, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op(1, "w8_mul", ALU_MUL, 32'hFF, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op(1, "w8_mulhu", ALU_MULHU, 32'hFF, 32'hFF, 32'hFE, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op(1, "w8_divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op(1, "w8_remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 9, 0);
    run_op(1, "w8_divu_by0", ALU_DIVU, 32'h42, 32'h0, 32'hFF, 1'b0, 1'b0, 1'b1, 1, 0);
    run_op(1, "w8_hold", ALU_MUL, 32'd13, 32'd11, 32'd143, 1'b0, 1'b0, 1'b0, 9, 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
